// File: rtl/fpga_io_tick_debounce.sv
// 100 Hz tick generator and two-button debouncer for the FPGA I/O block.
// Buttons are synchronised, then accepted only after DEBOUNCE_TICKS stable 100 Hz samples.
module fpga_io_tick_debounce #(
  parameter int CLK_FREQ_HZ    = 25000000,
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [1:0] buttons_raw,
  output logic       clk_100hz,
  output logic       tick_100hz,
  output logic [1:0] buttons,
  output logic [1:0] button_press
);

  localparam int          HALF_PERIOD = CLK_FREQ_HZ / 200;
  localparam logic [31:0] HALF_LAST   = 32'(HALF_PERIOD - 1);
  localparam logic [3:0]  DEB_LAST    = 4'(DEBOUNCE_TICKS - 1);

  logic [31:0]      div_cnt_r;
  logic             clk_100hz_r;
  logic             tick_r;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0][3:0]  deb_cnt_r;
  logic [1:0]       buttons_r;
  logic [1:0]       buttons_d_r;
  logic [1:0]       button_press_r;
  logic [1:0][3:0]  deb_cnt_nxt_s;
  logic [1:0]       buttons_nxt_s;

  // Half-period divider; the tick marks the low-to-high toggle of clk_100hz.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      div_cnt_r   <= 32'd0;
      clk_100hz_r <= 1'b0;
      tick_r      <= 1'b0;
    end else if (div_cnt_r == HALF_LAST) begin
      div_cnt_r   <= 32'd0;
      clk_100hz_r <= ~clk_100hz_r;
      tick_r      <= ~clk_100hz_r;
    end else begin
      div_cnt_r   <= div_cnt_r + 32'd1;
      clk_100hz_r <= clk_100hz_r;
      tick_r      <= 1'b0;
    end
  end

  // Debounce next-state: counters only move on a tick; any agreement clears progress.
  always_comb begin
    deb_cnt_nxt_s = deb_cnt_r;
    buttons_nxt_s = buttons_r;
    for (int i = 0; i < 2; i++) begin
      if (tick_r) begin
        if (sync2_r[i] == buttons_r[i]) begin
          deb_cnt_nxt_s[i] = 4'd0;
        end else if (deb_cnt_r[i] >= DEB_LAST) begin
          buttons_nxt_s[i] = sync2_r[i];
          deb_cnt_nxt_s[i] = 4'd0;
        end else begin
          deb_cnt_nxt_s[i] = deb_cnt_r[i] + 4'd1;
        end
      end else begin
        deb_cnt_nxt_s[i] = deb_cnt_r[i];
        buttons_nxt_s[i] = buttons_r[i];
      end
    end
  end

  // Synchroniser, debounce state and rising-edge press detection.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync1_r        <= 2'b00;
      sync2_r        <= 2'b00;
      deb_cnt_r      <= '0;
      buttons_r      <= 2'b00;
      buttons_d_r    <= 2'b00;
      button_press_r <= 2'b00;
    end else begin
      sync1_r        <= buttons_raw;
      sync2_r        <= sync1_r;
      deb_cnt_r      <= deb_cnt_nxt_s;
      buttons_r      <= buttons_nxt_s;
      buttons_d_r    <= buttons_r;
      button_press_r <= buttons_r & ~buttons_d_r;
    end
  end

  assign clk_100hz    = clk_100hz_r;
  assign tick_100hz   = tick_r;
  assign buttons      = buttons_r;
  assign button_press = button_press_r;

endmodule

// File: tb/tb_fpga_io_tick_debounce.sv
// Scoreboard bench: a cycle model predicts every output, expectations are queued per edge
// and popped when the DUT outputs settle, plus scenario-level checks on levels and press counts.
module tb_fpga_io_tick_debounce;

  localparam int HP  = 10;
  localparam int DEB = 3;

  logic       PCLK;
  logic       PRESET;
  logic [1:0] buttons_raw;
  logic       clk_100hz;
  logic       tick_100hz;
  logic [1:0] buttons;
  logic [1:0] button_press;

  fpga_io_tick_debounce #(
    .CLK_FREQ_HZ   (2000),
    .DEBOUNCE_TICKS(DEB)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .buttons_raw (buttons_raw),
    .clk_100hz   (clk_100hz),
    .tick_100hz  (tick_100hz),
    .buttons     (buttons),
    .button_press(button_press)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic       clk;
    logic       tick;
    logic [1:0] btn;
    logic [1:0] press;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // model state
  int unsigned m_n;
  logic [1:0]  m_s1, m_s2, m_btn, m_prev, m_press;
  int          m_cnt[2];

  // observation counters
  int press0_cnt, press1_cnt, both_cnt, tick_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [1:0] raw);
    logic eval;
    if (rst) begin
      m_n = 0; m_s1 = 2'b00; m_s2 = 2'b00; m_btn = 2'b00;
      m_prev = 2'b00; m_press = 2'b00; m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      eval    = ((m_n % (2 * HP)) == HP);
      m_press = m_btn & ~m_prev;
      m_prev  = m_btn;
      if (eval) begin
        for (int b = 0; b < 2; b++) begin
          if (m_s2[b] != m_btn[b]) begin
            m_cnt[b]++;
            if (m_cnt[b] == DEB) begin
              m_btn[b] = m_s2[b];
              m_cnt[b] = 0;
            end
          end else begin
            m_cnt[b] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_n++;
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] raw);
    exp_t e;
    exp_t got;
    @(negedge PCLK);
    PRESET      = rst;
    buttons_raw = raw;
    @(posedge PCLK);
    model_edge(rst, raw);
    e.clk   = ((m_n / HP) % 2) == 1;
    e.tick  = (m_n % (2 * HP)) == HP;
    e.btn   = m_btn;
    e.press = m_press;
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    check_eq("clk_100hz", clk_100hz, got.clk);
    check_eq("tick_100hz", tick_100hz, got.tick);
    check_eq("buttons", buttons, got.btn);
    check_eq("button_press", button_press, got.press);
    press0_cnt += button_press[0];
    press1_cnt += button_press[1];
    both_cnt   += (button_press == 2'b11) ? 1 : 0;
    tick_cnt   += tick_100hz;
  endtask

  task automatic run(input int n, input logic rst, input logic [1:0] raw);
    for (int k = 0; k < n; k++) step(rst, raw);
  endtask

  task automatic clear_counts();
    press0_cnt = 0; press1_cnt = 0; both_cnt = 0; tick_cnt = 0;
  endtask

  initial begin
    logic [1:0] raw_v;
    PRESET      = 1'b1;
    buttons_raw = 2'b00;
    m_n = 0; m_s1 = 2'b00; m_s2 = 2'b00; m_btn = 2'b00;
    m_prev = 2'b00; m_press = 2'b00; m_cnt[0] = 0; m_cnt[1] = 0;
    clear_counts();

    // reset state
    run(2, 1'b1, 2'b00);
    check_eq("rst_clk", clk_100hz, 32'd0);
    check_eq("rst_tick", tick_100hz, 32'd0);
    check_eq("rst_btn", buttons, 32'd0);
    check_eq("rst_press", button_press, 32'd0);

    // idle divider: ticks at 10, 30, 50 cycles after release
    clear_counts();
    run(60, 1'b0, 2'b00);
    check_eq("idle_ticks", tick_cnt, 32'd3);
    check_eq("idle_btn", buttons, 32'd0);

    // reset with deb_cnt[0]=2, div_cnt=7 discards progress
    run(1, 1'b1, 2'b00);
    run(37, 1'b0, 2'b01);
    run(1, 1'b1, 2'b01);
    check_eq("mid_rst_btn", buttons, 32'd0);
    check_eq("mid_rst_clk", clk_100hz, 32'd0);
    clear_counts();
    run(50, 1'b0, 2'b01);
    check_eq("post_rst_pending", buttons, 32'd0);
    run(5, 1'b0, 2'b01);
    check_eq("post_rst_accept", buttons, 32'd1);
    run(5, 1'b0, 2'b01);
    check_eq("post_rst_press0", press0_cnt, 32'd1);
    check_eq("post_rst_press1", press1_cnt, 32'd0);

    // release accepted after 3 ticks, no press pulse
    clear_counts();
    run(80, 1'b0, 2'b00);
    check_eq("release_btn", buttons, 32'd0);
    check_eq("release_press", press0_cnt, 32'd0);

    // bounce: 2 mismatching ticks then agreement clears the count
    run(1, 1'b1, 2'b00);
    clear_counts();
    run(40, 1'b0, 2'b01);
    run(40, 1'b0, 2'b00);
    check_eq("bounce_btn", buttons, 32'd0);
    check_eq("bounce_press", press0_cnt, 32'd0);
    run(49, 1'b0, 2'b01);
    check_eq("bounce_fresh_pending", buttons, 32'd0);
    run(11, 1'b0, 2'b01);
    check_eq("bounce_fresh_accept", buttons, 32'd1);
    check_eq("bounce_fresh_press", press0_cnt, 32'd1);

    // falling edge of bit 0
    clear_counts();
    run(80, 1'b0, 2'b00);
    check_eq("fall_btn", buttons, 32'd0);
    check_eq("fall_press", press0_cnt, 32'd0);

    // both bits together
    clear_counts();
    run(80, 1'b0, 2'b11);
    check_eq("both_btn", buttons, 32'd3);
    check_eq("both_press_same_cycle", both_cnt, 32'd1);
    check_eq("both_press1", press1_cnt, 32'd1);

    // random bouncing, checked cycle by cycle against the model
    raw_v = 2'b00;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 11) == 0) raw_v = 2'($urandom_range(0, 3));
      step(1'b0, raw_v);
    end

    if (sb_q.size() != 0) check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
